spi_ram_ctrl: RTL and testbench

SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

---
 rtl/spi_ram_pkg.sv | 22 ++
 rtl/spi_ram_if.sv | 22 ++
 rtl/spi_ram_array.sv | 24 ++
 rtl/spi_ram_ctrl.sv | 109 ++++++++++
 tb/tb_spi_ram_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-fronted RAM controller: command encodings,
// controller state type and default geometry.
package spi_ram_pkg;

  localparam int MEM_DEPTH_DEF = 256;
  localparam int ADDR_SIZE_DEF = 8;

  // Command field carried in rx_data[9:8].
  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/spi_ram_if.sv
// Frame/response bundle between an SPI slave front end (master side) and the
// RAM controller (slave side).
interface spi_ram_if;

  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;
  logic       seq_err;

  modport master (
    output rx_data, rx_valid,
    input  tx_data, tx_valid, busy, seq_err
  );

  modport slave (
    input  rx_data, rx_valid,
    output tx_data, tx_valid, busy, seq_err
  );

endinterface

// File: rtl/spi_ram_array.sv
// Single-port synchronous byte RAM with a one-cycle registered read port.
module spi_ram_array #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem [DEPTH];

  // Write and registered read share the single address port.
  // NOTE: storage has no reset on purpose; clearing a RAM array would force
  // flops instead of a memory macro and the contents must survive rst_n.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata     <= mem[addr];
  end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Frame decoder and read sequencer sitting between an SPI slave and a small
// internal RAM. Writes and address loads finish in IDLE; reads take two
// extra cycles (issue, response) during which new frames are dropped.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input logic     clk,
  input logic     rst_n,
  spi_ram_if.slave bus
);

  state_e               state_q, state_d;
  cmd_e                 cmd;
  logic [ADDR_SIZE-1:0] wr_addr_q, rd_addr_q, mem_addr;
  logic                 rd_addr_vld_q;
  logic [7:0]           tx_data_q, mem_rdata;
  logic                 tx_valid_q, seq_err_q;
  logic                 busy, rd_illegal, accept, err_d;
  logic                 mem_we, mem_re;

  assign cmd        = cmd_e'(bus.rx_data[9:8]);
  assign busy       = (state_q != IDLE);
  assign rd_illegal = (cmd == CMD_RD_DATA) && !rd_addr_vld_q;
  assign accept     = bus.rx_valid && (state_q == IDLE) && !rd_illegal;
  assign err_d      = bus.rx_valid && (busy || rd_illegal);
  assign mem_addr   = mem_we ? wr_addr_q : rd_addr_q;

  // Next-state and RAM strobes for the read sequencer.
  // NOTE: every output is defaulted first so no path through the case leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    case (state_q)
      IDLE: begin
        mem_we = accept && (cmd == CMD_WR_DATA);
        if (accept && (cmd == CMD_RD_DATA)) state_d = RD_ISSUE;
      end
      RD_ISSUE: begin
        mem_re  = 1'b1;
        state_d = RD_RESP;
      end
      RD_RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any read in flight.
  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Address pointers, response register and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      rd_addr_vld_q <= 1'b0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      seq_err_q     <= 1'b0;
    end else begin
      seq_err_q <= err_d;
      if (accept) begin
        // Any accepted frame retires the previously held response.
        tx_valid_q <= 1'b0;
        case (cmd)
          CMD_WR_ADDR: wr_addr_q <= bus.rx_data[ADDR_SIZE-1:0];
          CMD_WR_DATA: wr_addr_q <= wr_addr_q + 1'b1;
          CMD_RD_ADDR: begin
            rd_addr_q     <= bus.rx_data[ADDR_SIZE-1:0];
            rd_addr_vld_q <= 1'b1;
          end
          default: ;
        endcase
      end
      if (state_q == RD_RESP) begin
        tx_data_q  <= mem_rdata;
        tx_valid_q <= 1'b1;
        rd_addr_q  <= rd_addr_q + 1'b1;
      end
    end
  end

  spi_ram_array #(
    .DEPTH (MEM_DEPTH),
    .ADDR_W(ADDR_SIZE)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .re   (mem_re),
    .addr (mem_addr),
    .wdata(bus.rx_data[7:0]),
    .rdata(mem_rdata)
  );

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.busy     = busy;
  assign bus.seq_err  = seq_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Self-checking bench for spi_ram_ctrl: directed scenarios with literal
// expectations, then randomized frames against a transaction-level model.
module tb_spi_ram_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  spi_ram_if bus();

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_mem   [256];
  bit         m_known [256];
  logic [7:0] m_wr = 8'h00, m_rd = 8'h00, m_pend = 8'h00, m_tx_data = 8'h00;
  bit         m_vld = 1'b0, m_tx_valid = 1'b0, m_tx_known = 1'b0, m_err = 1'b0;
  int         m_busy_left = 0;
  logic [1:0] m_cmd;
  logic [7:0] m_pl;

  initial for (int i = 0; i < 256; i++) m_known[i] = 1'b0;

  // A read occupies the two edges after its acceptance; the response lands
  // on the second one. Anything arriving in that window is refused.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wr = 8'h00; m_rd = 8'h00; m_vld = 1'b0; m_tx_data = 8'h00;
      m_tx_valid = 1'b0; m_err = 1'b0; m_busy_left = 0;
    end else begin
      m_err = 1'b0;
      if (m_busy_left > 0) begin
        if (bus.rx_valid) m_err = 1'b1;
        m_busy_left--;
        if (m_busy_left == 0) begin
          m_tx_data  = m_mem[m_pend];
          m_tx_known = m_known[m_pend];
          m_tx_valid = 1'b1;
          m_rd++;
        end
      end else if (bus.rx_valid) begin
        m_cmd = bus.rx_data[9:8];
        m_pl  = bus.rx_data[7:0];
        if (m_cmd == 2'b11 && !m_vld) m_err = 1'b1;
        else begin
          m_tx_valid = 1'b0;
          case (m_cmd)
            2'b00: m_wr = m_pl;
            2'b01: begin m_mem[m_wr] = m_pl; m_known[m_wr] = 1'b1; m_wr++; end
            2'b10: begin m_rd = m_pl; m_vld = 1'b1; end
            default: begin m_pend = m_rd; m_busy_left = 2; end
          endcase
        end
      end
    end
  end

  // Continuous comparison on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("busy",     32'(bus.busy),     32'(m_busy_left > 0));
      check("tx_valid", 32'(bus.tx_valid), 32'(m_tx_valid));
      check("seq_err",  32'(bus.seq_err),  32'(m_err));
      if (m_tx_valid && m_tx_known)
        check("tx_data", 32'(bus.tx_data), 32'(m_tx_data));
    end
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic frame(input logic [9:0] f);
    bus.rx_data  = f;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    idle(2);
    check("rst_busy",     32'(bus.busy),     32'h0);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
    check("rst_tx_data",  32'(bus.tx_data),  32'h0);
    check("rst_seq_err",  32'(bus.seq_err),  32'h0);
    rst_n = 1'b1;

    // Write-then-read with exact latency.
    frame(10'h000); frame(10'h1A5); frame(10'h200); frame(10'h300);
    check("wr_rd_busy_n",      32'(bus.busy),     32'h1);
    check("wr_rd_txv_n",       32'(bus.tx_valid), 32'h0);
    idle(1);
    check("wr_rd_busy_n1",     32'(bus.busy),     32'h1);
    check("wr_rd_txv_n1",      32'(bus.tx_valid), 32'h0);
    idle(1);
    check("wr_rd_busy_n2",     32'(bus.busy),     32'h0);
    check("wr_rd_txv_n2",      32'(bus.tx_valid), 32'h1);
    check("wr_rd_data",        32'(bus.tx_data),  32'hA5);

    // Response held through idle, cleared by the next accepted frame.
    idle(20);
    check("hold_txv",   32'(bus.tx_valid), 32'h1);
    check("hold_data",  32'(bus.tx_data),  32'hA5);
    frame(10'h005);
    check("hold_clear", 32'(bus.tx_valid), 32'h0);

    // Read with no read address loaded since reset.
    do_reset();
    frame(10'h300);
    check("illegal_err",  32'(bus.seq_err),  32'h1);
    check("illegal_busy", 32'(bus.busy),     32'h0);
    check("illegal_txv",  32'(bus.tx_valid), 32'h0);
    idle(1);
    check("illegal_err_clr", 32'(bus.seq_err), 32'h0);

    // Address wrap on both pointers.
    frame(10'h0FF); frame(10'h111); frame(10'h122); frame(10'h2FF);
    frame(10'h300); idle(2);
    check("wrap_rd_ff", 32'(bus.tx_data), 32'h11);
    frame(10'h300); idle(2);
    check("wrap_rd_00", 32'(bus.tx_data), 32'h22);

    // Frame dropped while a read is in flight.
    frame(10'h010); frame(10'h15A); frame(10'h177);
    frame(10'h210); frame(10'h300); frame(10'h011);
    check("drop_err",  32'(bus.seq_err), 32'h1);
    check("drop_busy", 32'(bus.busy),    32'h1);
    idle(1);
    check("drop_rd_data", 32'(bus.tx_data), 32'h5A);
    check("drop_err_clr", 32'(bus.seq_err), 32'h0);
    frame(10'h1CC); frame(10'h211); frame(10'h300); idle(2);
    check("drop_no_effect_11", 32'(bus.tx_data), 32'h77);
    frame(10'h300); idle(2);
    check("drop_no_effect_12", 32'(bus.tx_data), 32'hCC);

    // Reset in the middle of a read.
    frame(10'h210); frame(10'h300);
    @(posedge clk); #1 rst_n = 1'b0; #1;
    check("midrst_busy",  32'(bus.busy),     32'h0);
    check("midrst_txv",   32'(bus.tx_valid), 32'h0);
    check("midrst_data",  32'(bus.tx_data),  32'h0);
    check("midrst_err",   32'(bus.seq_err),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    frame(10'h210);
    idle(3);
    check("midrst_no_txv", 32'(bus.tx_valid), 32'h0);
    frame(10'h300); idle(2);
    check("midrst_mem_kept", 32'(bus.tx_data), 32'h5A);

    // Fill the whole array so every later read is predictable.
    frame(10'h000);
    for (int i = 0; i < 256; i++) frame({2'b01, 8'($urandom_range(0, 255))});

    // Randomized traffic, including drops, illegal reads and resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      bus.rx_valid = ($urandom_range(0, 99) < 55);
      bus.rx_data  = 10'($urandom_range(0, 1023));
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
